// File: rtl/output_buffer_drain.sv
// Output buffer: captures accumulator results into a 16-entry buffer and drains 0..N-1 in order over valid/ready.
// Latency 2 cycles drain_start->first beat, one beat per 2 cycles; stalls in FETCH on unwritten entries, holds beat until out_ready.
// Optional: OUTBUF_CLEAR_ON_READ_EN makes a drained entry consumed (valid cleared on handshake).
module output_buffer_drain #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear,
    input  logic              drain_start,
    input  logic [ADDR_W:0]   drain_count,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              ovw_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovw_err_q, ovw_err_d;
    logic                hs;
    logic                consume;

    logic [DATA_W-1:0]   mem [DEPTH];

    assign hs = (state_q == S_PRESENT) && out_valid_q && out_ready;

`ifdef OUTBUF_CLEAR_ON_READ_EN
    assign consume = hs;
`else
    assign consume = 1'b0;
`endif

    // Storage is not reset; only the valid bits qualify its contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A same-cycle write beats both clear and consume for its own entry.
    always_comb begin
        valid_d   = valid_q;
        ovw_err_d = ovw_err_q;
        if (clear) begin
            valid_d = '0;
        end else if (consume) begin
            valid_d[out_addr_q] = 1'b0;
        end
        if (wr_en) begin
            valid_d[wr_addr] = 1'b1;
            if (valid_q[wr_addr] && !clear && !(consume && (out_addr_q == wr_addr))) begin
                ovw_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_ptr_d    = rd_ptr_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (clear) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (drain_start) begin
                        cnt_d    = (drain_count > DEPTH_CNT) ? DEPTH_CNT : drain_count;
                        rd_ptr_d = '0;
                        busy_d   = 1'b1;
                        state_d  = (drain_count == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (valid_q[rd_ptr_q]) begin
                        out_data_d  = mem[rd_ptr_q];
                        out_addr_d  = rd_ptr_q;
                        out_valid_d = 1'b1;
                        state_d     = S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (hs) begin
                        cnt_d       = cnt_q - 1'b1;
                        rd_ptr_d    = (rd_ptr_q == LAST_PTR) ? rd_ptr_q : rd_ptr_q + 1'b1;
                        out_valid_d = 1'b0;
                        state_d     = (cnt_q == 1) ? S_DONE : S_FETCH;
                    end
                end
                S_DONE: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovw_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovw_err_q   <= ovw_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ovw_err   = ovw_err_q;

endmodule

// File: tb/tb_output_buffer_drain.sv
// Bench for output_buffer_drain: drain-scenario table plus hand-written stall, backpressure, clear and overwrite sequences.
module tb_output_buffer_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        clear;
    logic        drain_start;
    logic [4:0]  drain_count;
    logic [31:0] out_data;
    logic [3:0]  out_addr;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        ovw_err;

    output_buffer_drain dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clear(clear), .drain_start(drain_start), .drain_count(drain_count),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .ovw_err(ovw_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic [4:0]  count;
        logic [31:0] base;
        int          beats;
        int          lat;
    } vec_t;

    beat_t       sb[$];
    vec_t        tv[6];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc_n = 0;
    int          done_cnt = 0;
    int          done_n = 0;
    int          first_vld_n = -1;
    int          start_n = 0;
    int          hs_cnt = 0;
    logic        s_valid;
    logic [31:0] s_data;
    logic [3:0]  s_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample/score at negedge, return 1 time unit after posedge.
    task automatic cyc();
        beat_t e;
        @(negedge clk);
        cyc_n++;
        s_valid = out_valid;
        s_data  = out_data;
        s_addr  = out_addr;
        if (done) begin
            done_cnt++;
            done_n = cyc_n;
        end
        if (out_valid && first_vld_n < 0) first_vld_n = cyc_n;
        if (out_valid && out_ready) begin
            hs_cnt++;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_beat: got addr %0d data %h, none expected", out_addr, out_data);
            end else begin
                e = sb.pop_front();
                if (out_addr !== e.addr || out_data !== e.data) begin
                    miscompares++;
                    $display("FAIL beat: got addr %0d data %h expected addr %0d data %h",
                             out_addr, out_data, e.addr, e.data);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; clear = 1'b0; drain_start = 1'b0; out_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        sb.delete();
        done_cnt = 0;
        first_vld_n = -1;
        cyc();
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic push_beats(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) sb.push_back(beat_t'{addr: 4'(i), data: base + 32'(i)});
    endtask

    task automatic start_drain(input logic [4:0] n);
        drain_start = 1'b1; drain_count = n;
        start_n = cyc_n + 1;
        first_vld_n = -1;
        cyc();
        drain_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        int i;
        d0 = done_cnt;
        i = 0;
        while (done_cnt == d0 && i < budget) begin
            cyc();
            i++;
        end
        chk(name, 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (s_valid) break;
        end
    endtask

    initial begin
        int n_w;
        int d0;
        int h0;

        tv[0] = '{5'd16, 32'h3F80_0000, 16, 2};
        tv[1] = '{5'd0,  32'h0000_0000, 0,  2};
        tv[2] = '{5'd1,  32'h4000_0000, 1,  2};
        tv[3] = '{5'd5,  32'h4100_0010, 5,  2};
        tv[4] = '{5'd17, 32'h4200_0020, 16, 2};
        tv[5] = '{5'd31, 32'h4300_0030, 16, 2};

        wr_addr = '0; wr_data = '0; drain_count = '0;
        rst = 1'b1; wr_en = 1'b0; clear = 1'b0; drain_start = 1'b0; out_ready = 1'b0;
        cyc();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_done",      64'(done),      64'd0);
        chk("rst_ovw_err",   64'(ovw_err),   64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_addr",  64'(out_addr),  64'd0);

        for (int k = 0; k < 6; k++) begin
            do_reset();
            out_ready = 1'b1;
            for (int i = 0; i < 16; i++) wr(i, tv[k].base + 32'(i));
            push_beats(tv[k].beats, tv[k].base);
            start_drain(tv[k].count);
            chk("tbl_busy_after_start", 64'(busy), 64'd1);
            wait_done("tbl_done", 60);
            chk("tbl_all_beats", 64'(sb.size()), 64'd0);
            if (tv[k].beats > 0) chk("tbl_first_latency", 64'(first_vld_n - start_n), 64'(tv[k].lat));
            else                 chk("tbl_done_latency",  64'(done_n - start_n),      64'(tv[k].lat));
            chk("tbl_busy_after_done", 64'(busy), 64'd0);
            cyc(); cyc();
            chk("tbl_done_once", 64'(done_cnt), 64'd1);
            chk("tbl_idle_valid", 64'(out_valid), 64'd0);
        end

        // Stall on an unwritten entry, ignored drain_start, release by a late write.
        do_reset();
        out_ready = 1'b1;
        wr(0, 32'hA000_0000);
        wr(1, 32'hA000_0001);
        push_beats(2, 32'hA000_0000);
        sb.push_back(beat_t'{addr: 4'd2, data: 32'hC000_0000});
        start_drain(5'd3);
        for (int i = 0; i < 12; i++) cyc();
        chk("stall_pending", 64'(sb.size()), 64'd1);
        chk("stall_valid", 64'(out_valid), 64'd0);
        chk("stall_busy", 64'(busy), 64'd1);
        drain_start = 1'b1; drain_count = 5'd1;
        cyc();
        drain_start = 1'b0;
        cyc(); cyc();
        n_w = cyc_n + 1;
        wr(2, 32'hC000_0000);
        wait_valid(10);
        chk("stall_release_latency", 64'(cyc_n - n_w), 64'd2);
        wait_done("stall_done", 20);
        chk("stall_all_beats", 64'(sb.size()), 64'd0);

        // Backpressure: beat 0 held for 5 cycles.
        do_reset();
        wr(0, 32'hB000_0000);
        wr(1, 32'hB000_0001);
        push_beats(2, 32'hB000_0000);
        out_ready = 1'b0;
        start_drain(5'd2);
        wait_valid(10);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_hold", {31'd0, s_valid, s_addr, s_data}, {31'd0, 1'b1, 4'd0, 32'hB000_0000});
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_first_ready_pops", 64'(sb.size()), 64'd1);
        wait_done("bp_done", 20);
        chk("bp_all_beats", 64'(sb.size()), 64'd0);

        // Overwrite error, and clear+write on the same entry.
        do_reset();
        wr(5, 32'h1);
        cyc();
        chk("ovw_single_write", 64'(ovw_err), 64'd0);
        wr(7, 32'h2);
        clear = 1'b1;
        wr(7, 32'h3);
        clear = 1'b0;
        cyc();
        chk("ovw_clear_with_write", 64'(ovw_err), 64'd0);
        wr(7, 32'h4);
        cyc();
        chk("ovw_write_beats_clear", 64'(ovw_err), 64'd1);
        do_reset();
        wr(5, 32'h5);
        wr(5, 32'h6);
        cyc();
        chk("ovw_set", 64'(ovw_err), 64'd1);
        for (int i = 0; i < 4; i++) cyc();
        chk("ovw_sticky", 64'(ovw_err), 64'd1);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        cyc();
        chk("ovw_survives_clear", 64'(ovw_err), 64'd1);
        do_reset();
        chk("ovw_reset", 64'(ovw_err), 64'd0);

        // Clear while beat 1 is presented.
        do_reset();
        for (int i = 0; i < 4; i++) wr(i, 32'hD000_0000 + 32'(i));
        push_beats(4, 32'hD000_0000);
        out_ready = 1'b0;
        start_drain(5'd4);
        wait_valid(10);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        wait_valid(10);
        chk("clr_on_beat1", {60'd0, s_addr}, 64'd1);
        d0 = done_cnt;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clr_valid_low", 64'(out_valid), 64'd0);
        chk("clr_busy_low", 64'(busy), 64'd0);
        for (int i = 0; i < 4; i++) cyc();
        chk("clr_no_done", 64'(done_cnt - d0), 64'd0);
        sb.delete();
        out_ready = 1'b1;
        h0 = hs_cnt;
        start_drain(5'd1);
        for (int i = 0; i < 10; i++) cyc();
        chk("clr_redrain_stalls", 64'(busy), 64'd1);
        chk("clr_redrain_no_beats", 64'(hs_cnt - h0), 64'd0);
        clear = 1'b1;
        cyc();
        clear = 1'b0;

        // Second drain of the same entries.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) wr(i, 32'hE000_0000 + 32'(i));
        push_beats(4, 32'hE000_0000);
        start_drain(5'd4);
        wait_done("replay_first_done", 30);
        chk("replay_first_beats", 64'(sb.size()), 64'd0);
        cyc();
        h0 = hs_cnt;
`ifdef OUTBUF_CLEAR_ON_READ_EN
        start_drain(5'd4);
        for (int i = 0; i < 12; i++) cyc();
        chk("consumed_stalls", 64'(busy), 64'd1);
        chk("consumed_no_beats", 64'(hs_cnt - h0), 64'd0);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
`else
        push_beats(4, 32'hE000_0000);
        start_drain(5'd4);
        wait_done("replay_second_done", 30);
        chk("replay_second_beats", 64'(hs_cnt - h0), 64'd4);
        chk("replay_all_matched", 64'(sb.size()), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/output_buffer_drain.md
Name: output_buffer_drain

Overview:
- Receive side of the accumulator-to-output-buffer write interface.
- Captures 32-bit results at 4-bit addresses into a 16-entry buffer and tracks one valid bit per entry.
- On command, drains entries 0..N-1 in address order to a downstream consumer over a valid/ready stream.
- Stalls on any entry the accumulator has not yet written.
- Sits between the accumulator and the host/readback path.

Parameters:
- DEPTH, 16, number of buffer entries; must equal 2^ADDR_W.
- ADDR_W, 4, write/read address width.
- DATA_W, 32, entry width (bfp32 word).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- wr_en  in  1  write strobe from accumulator (output_buffer_enable)
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- clear  in  1  synchronous clear of all valid bits; aborts any drain
- drain_start  in  1  one-cycle pulse; starts a drain
- drain_count  in  ADDR_W+1  entries to drain; sampled on drain_start
- out_data  out  DATA_W  stream data
- out_addr  out  ADDR_W  address of the current out_data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready from consumer
- busy  out  1  high from the cycle after drain_start until DONE
- done  out  1  one-cycle pulse when a drain completes
- ovw_err  out  1  sticky; a write hit an entry whose valid bit was already 1

Behaviour:
- Reset (async, rst=1):
  - FSM=IDLE; all valid bits=0.
  - out_valid, busy, done, ovw_err = 0.
  - out_data, out_addr = 0.
  - Memory contents are not reset.
- Write path (always active, every state):
  - wr_en=1 stores wr_data at mem[wr_addr] and sets valid[wr_addr] on the next edge.
  - If valid[wr_addr] was already 1, ovw_err is set and stays set until rst.
  - The write still occurs.
- FSM states: IDLE, FETCH, PRESENT, DONE.
- IDLE:
  - drain_start=1 latches cnt=min(drain_count,16), sets rd_ptr=0 and busy=1.
  - Next state is FETCH if cnt>0, else DONE.
- FETCH:
  - If valid[rd_ptr]=1: out_data<=mem[rd_ptr], out_addr<=rd_ptr, out_valid<=1, next state PRESENT.
  - Otherwise stay in FETCH (stall) with out_valid=0.
  - valid is a registered bit, so a write to rd_ptr is visible to FETCH one cycle after the write edge.
- PRESENT:
  - out_valid, out_data and out_addr hold stable until out_valid&&out_ready.
  - On handshake: rd_ptr++ and cnt--.
  - If cnt reaches 0: out_valid<=0, next state DONE.
  - Otherwise: out_valid<=0, next state FETCH.
  - This gives at most one transfer per 2 cycles.
- DONE: done=1 for exactly one cycle, busy<=0, next state IDLE.
- Latency:
  - drain_start to first out_valid is 2 cycles when entry 0 is valid (IDLE->FETCH->PRESENT).
  - Each subsequent beat follows 2 cycles after the previous handshake, absent stalls.
- drain_start outside IDLE is ignored.
- drain_count=0: no beats; done pulses 2 cycles after drain_start.
- drain_count>16 is clamped to 16.
- rd_ptr stops at 15 and does not wrap.
- clear=1:
  - Clears all valid bits.
  - In any non-IDLE state: FSM goes to IDLE, out_valid=0, busy=0, and no done pulse.
  - clear and wr_en in the same cycle: the write wins for valid[wr_addr], and no ovw_err is raised.
  - clear has priority over drain_start.
- rst mid-drain aborts immediately to the reset values; a partially presented beat is lost.
- out_ready is ignored while out_valid=0.

Optional Feature:
- Macro: OUTBUF_CLEAR_ON_READ_EN.
- Defined:
  - A PRESENT handshake clears valid[out_addr], so each entry is consumed once.
  - A wr_en to the same address in the handshake cycle wins: valid stays 1 and no ovw_err.
  - A second drain without intervening writes stalls in FETCH at entry 0.
- Undefined:
  - Valid bits are cleared only by clear or rst.
  - Entries may be re-drained any number of times.

Test Plan:
- Write 0x3F800000..0x3F80000F to addr 0..15, then drain_start with drain_count=16 and out_ready=1 -> 16 beats, out_addr 0..15 with matching data; first out_valid 2 cycles after drain_start; done pulses once; busy low afterward.
- Write addr 0,1 only, then drain_count=3 -> beats 0,1, then out_valid=0 stall; write 0xC0000000 to addr 2 -> beat 2 appears 2 cycles after the write edge; done follows.
- Drain_count=2 with out_ready=0 for 5 cycles on beat 0 -> out_data/out_addr held stable; beat completes on the first out_ready=1 cycle.
- Write addr 5 twice -> ovw_err=1 and stays 1; a later clear does not reset it; rst does.
- Assert clear during PRESENT of beat 1 -> out_valid=0 next cycle, busy=0, no done pulse, all valid bits=0 (a subsequent drain_count=1 stalls).
- OUTBUF_CLEAR_ON_READ_EN defined: drain 4 entries, then drain_start with drain_count=4 again -> stall at addr 0. Undefined: the second drain replays the same 4 beats.
